arbitro_barramento: RTL and testbench

Round-robin arbiter sharing the 16-bit, 8-source datapath multiplexer among eight requesters. Each requester raises a request and holds it while it owns the path. The arbiter grants one requester at a time and drives the multiplexer's 3-bit select with the owner's index. Optionally, it limits ownership length so no requester can starve the others.

---
 rtl/arbitro_barramento.sv | 179 +++++++++++++++++
 tb/tb_arbitro_barramento.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/arbitro_barramento.sv
// -----------------------------------------------------------------------------
// arbitro_barramento
// Round-robin arbiter for the shared 16-bit, 8-source datapath multiplexer.
// One requester at a time owns the path. The owner's index drives the mux select.
// Ownership passes to the next pending requester, searching from the last
// owner + 1 with wrap-around.
//
// Optional feature (macro ARBITRO_TIMEOUT_EN):
//   An ownership counter forces a handoff after MAX_CICLOS consecutive owned
//   cycles, but only when another requester is waiting. With the macro
//   undefined, no counter exists and MAX_CICLOS only has its range checked.
//
// Parameters:
//   MAX_CICLOS  maximum consecutive owned cycles (2..256), timeout build only
// Ports:
//   clk        in   1  clock, rising edge
//   reset      in   1  synchronous active-high reset
//   pedido     in   8  request vector, bit i = requester i
//   concessao  out  8  one-hot grant, registered, zero when idle
//   controle   out  3  mux select = owner index, registered, holds when idle
//   ocupado    out  1  registered, high while a grant is active
// -----------------------------------------------------------------------------
module arbitro_barramento #(
    parameter int MAX_CICLOS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pedido,
    output logic [7:0] concessao,
    output logic [2:0] controle,
    output logic       ocupado
);

    // Reject out-of-range limits at elaboration time.
    if ((MAX_CICLOS < 2) || (MAX_CICLOS > 256)) begin : g_max_ciclos_invalido
        $error("arbitro_barramento: MAX_CICLOS must be in 2..256");
    end

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        ATIVO  = 1'b1
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [2:0] dono_q, dono_d;
    logic [2:0] ultimo_q, ultimo_d;
    logic [7:0] concessao_q, concessao_d;
    logic [2:0] controle_q, controle_d;
    logic       ocupado_q, ocupado_d;

    logic [7:0] outros_s;         // pending requests excluding the owner
    logic [3:0] venc_ocioso_s;    // {found, index} for the search from idle
    logic [3:0] venc_troca_s;     // {found, index} for a handoff search
    logic       expira_s;         // timeout forces a handoff on this edge

`ifdef ARBITRO_TIMEOUT_EN
    localparam logic [7:0] LIMITE = 8'(MAX_CICLOS - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    // Returns {found, index}. The search starts at base+1 and wraps modulo 8,
    // so base itself is tried last. The loop runs from the farthest candidate
    // to the nearest, so the nearest set bit is the one that remains.
    function automatic logic [3:0] busca(input logic [7:0] req, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 8; k >= 1; k--) begin
            idx = base + 3'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        estado_d    = estado_q;
        dono_d      = dono_q;
        ultimo_d    = ultimo_q;
        concessao_d = concessao_q;
        controle_d  = controle_q;
        ocupado_d   = ocupado_q;
`ifdef ARBITRO_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        outros_s      = pedido & ~(8'b0000_0001 << dono_q);
        venc_ocioso_s = busca(pedido, ultimo_q);
        // After a release or timeout, ultimo becomes dono, so the search
        // starts at dono+1. The owner is masked out, so it wins again only
        // through the idle path, when it is the only requester left.
        venc_troca_s  = busca(outros_s, dono_q);

`ifdef ARBITRO_TIMEOUT_EN
        expira_s = (cnt_q == LIMITE) && (outros_s != 8'h00);
`else
        expira_s = 1'b0;
`endif

        case (estado_q)
            OCIOSO: begin
                if (pedido != 8'h00) begin
                    estado_d    = ATIVO;
                    dono_d      = venc_ocioso_s[2:0];
                    concessao_d = 8'b0000_0001 << venc_ocioso_s[2:0];
                    controle_d  = venc_ocioso_s[2:0];
                    ocupado_d   = 1'b1;
`ifdef ARBITRO_TIMEOUT_EN
                    cnt_d       = 8'h00;
`endif
                end else begin
                    estado_d = OCIOSO;
                end
            end
            ATIVO: begin
                if (!pedido[dono_q] || expira_s) begin
                    ultimo_d = dono_q;
                    if (venc_troca_s[3]) begin
                        // Direct handoff, with no idle cycle between owners.
                        dono_d      = venc_troca_s[2:0];
                        concessao_d = 8'b0000_0001 << venc_troca_s[2:0];
                        controle_d  = venc_troca_s[2:0];
`ifdef ARBITRO_TIMEOUT_EN
                        cnt_d       = 8'h00;
`endif
                    end else begin
                        estado_d    = OCIOSO;
                        concessao_d = 8'h00;
                        ocupado_d   = 1'b0;
                    end
                end else begin
`ifdef ARBITRO_TIMEOUT_EN
                    // At the limit with nobody waiting, the owner keeps the
                    // grant and a new window starts.
                    cnt_d = (cnt_q == LIMITE) ? 8'h00 : (cnt_q + 8'h01);
`endif
                    estado_d = ATIVO;
                end
            end
            default: begin
                estado_d    = OCIOSO;
                concessao_d = 8'h00;
                ocupado_d   = 1'b0;
            end
        endcase
    end

    // State and registered-output update, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            dono_q      <= 3'd0;
            ultimo_q    <= 3'd7;
            concessao_q <= 8'h00;
            controle_q  <= 3'd0;
            ocupado_q   <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
            cnt_q       <= 8'h00;
`endif
        end else begin
            estado_q    <= estado_d;
            dono_q      <= dono_d;
            ultimo_q    <= ultimo_d;
            concessao_q <= concessao_d;
            controle_q  <= controle_d;
            ocupado_q   <= ocupado_d;
`ifdef ARBITRO_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign concessao = concessao_q;
    assign controle  = controle_q;
    assign ocupado   = ocupado_q;

endmodule

// File: tb/tb_arbitro_barramento.sv
// -----------------------------------------------------------------------------
// tb_arbitro_barramento
// Directed bench for arbitro_barramento. Tracks the owner as an integer in a
// behavioural model and checks the DUT against it on every falling edge.
// Hand-computed literal expectations pin the model at key points.
// Build with or without ARBITRO_TIMEOUT_EN. The DUT is instantiated with
// MAX_CICLOS=4.
// -----------------------------------------------------------------------------
module tb_arbitro_barramento;

    localparam int MAXC = 4;
`ifdef ARBITRO_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pedido;
    logic [7:0] concessao;
    logic [2:0] controle;
    logic       ocupado;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model state: owner index, or -1 when idle.
    int m_dono   = -1;
    int m_ultimo = 7;
    int m_cnt    = 0;
    int m_ctrl   = 0;

    arbitro_barramento #(.MAX_CICLOS(MAXC)) dut (
        .clk       (clk),
        .reset     (reset),
        .pedido    (pedido),
        .concessao (concessao),
        .controle  (controle),
        .ocupado   (ocupado)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, act, exp, $time);
        end
    endtask

    // First pending requester after 'from', wrapping modulo 8, skipping 'excl'.
    function automatic int pick(input logic [7:0] req, input int from, input int excl);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (from + k) % 8;
            if (i != excl && req[i]) return i;
        end
        return -1;
    endfunction

    // Behavioural reference: who owns the bus after this edge.
    always @(posedge clk) begin
        int d, u, c, x, w;
        d = m_dono; u = m_ultimo; c = m_cnt; x = m_ctrl;
        if (reset) begin
            d = -1; u = 7; c = 0; x = 0;
        end else if (d < 0) begin
            if (pedido != 8'h00) begin
                d = pick(pedido, u, -1); c = 0; x = d;
            end
        end else if (!pedido[d] ||
                     (TO && c == MAXC - 1 && (pedido & ~(8'h01 << d)) != 8'h00)) begin
            u = d;
            w = pick(pedido, d, d);
            d = w;
            c = 0;
            if (w >= 0) x = w;
        end else begin
            c = (c == MAXC - 1) ? 0 : c + 1;
        end
        m_dono <= d; m_ultimo <= u; m_cnt <= c; m_ctrl <= x;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_concessao", {24'h0, concessao}, (m_dono < 0) ? 32'h0 : (32'h1 << m_dono));
            check("model_controle", {29'h0, controle}, m_ctrl);
            check("model_ocupado", {31'h0, ocupado}, (m_dono >= 0) ? 32'h1 : 32'h0);
        end
    end

    typedef struct {
        logic [7:0] vec;
        int         ciclos;
    } passo_t;

    passo_t tabela [8] = '{
        '{8'hFF, 3}, '{8'hF7, 2}, '{8'h0F, 2}, '{8'h0E, 2},
        '{8'h00, 2}, '{8'h90, 3}, '{8'h10, 2}, '{8'h00, 1}
    };

    initial begin
        reset  = 1'b1;
        pedido = 8'h00;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_concessao", {24'h0, concessao}, 32'h00);
        check("reset_controle", {29'h0, controle}, 32'h0);
        check("reset_ocupado", {31'h0, ocupado}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_concessao", {24'h0, concessao}, 32'h00);
            check("idle_ocupado", {31'h0, ocupado}, 32'h0);
        end

        // Single request from idle, then release.
        pedido = 8'h01;
        @(negedge clk);
        check("grant0_concessao", {24'h0, concessao}, 32'h01);
        check("grant0_ocupado", {31'h0, ocupado}, 32'h1);
        pedido = 8'h00;
        @(negedge clk);
        check("release0_concessao", {24'h0, concessao}, 32'h00);
        check("release0_ocupado", {31'h0, ocupado}, 32'h0);
        check("release0_controle", {29'h0, controle}, 32'h0);

        // Requesters 2, 5 and 7, each owning for 3 cycles.
        pedido = 8'hA4;
        @(negedge clk);
        check("rr_first", {29'h0, controle}, 32'h2);
        repeat (2) @(negedge clk);
        pedido = 8'hA0;
        @(negedge clk);
        check("rr_handoff5_conc", {24'h0, concessao}, 32'h20);
        check("rr_handoff5_ctrl", {29'h0, controle}, 32'h5);
        repeat (2) @(negedge clk);
        pedido = 8'h80;
        @(negedge clk);
        check("rr_handoff7_conc", {24'h0, concessao}, 32'h80);
        check("rr_handoff7_ctrl", {29'h0, controle}, 32'h7);

        // Requester 0 waits without preempting, then wins by wrap-around.
        pedido = 8'h81;
        repeat (2) @(negedge clk);
        check("no_preempt", {24'h0, concessao}, 32'h80);
        pedido = 8'h01;
        @(negedge clk);
        check("wrap_conc", {24'h0, concessao}, 32'h01);
        check("wrap_ctrl", {29'h0, controle}, 32'h0);
        pedido = 8'h00;
        @(negedge clk);
        check("wrap_idle_ocupado", {31'h0, ocupado}, 32'h0);

        // Requesters 1 and 2 held, to exercise the timeout.
        pedido = 8'h06;
        @(negedge clk);
        check("to_first", {24'h0, concessao}, 32'h02);
        repeat (4) @(negedge clk);
        check("to_second", {24'h0, concessao}, TO ? 32'h04 : 32'h02);
        repeat (4) @(negedge clk);
        check("to_third", {24'h0, concessao}, 32'h02);
        pedido = 8'h00;
        @(negedge clk);

        // Reset while requester 3 owns the bus.
        pedido = 8'h08;
        @(negedge clk);
        check("own3_ctrl", {29'h0, controle}, 32'h3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_conc", {24'h0, concessao}, 32'h00);
        check("midreset_ctrl", {29'h0, controle}, 32'h0);
        check("midreset_ocup", {31'h0, ocupado}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("regrant3_conc", {24'h0, concessao}, 32'h08);
        check("regrant3_ctrl", {29'h0, controle}, 32'h3);

        // Further patterns, checked only against the model.
        for (int s = 0; s < 8; s++) begin
            pedido = tabela[s].vec;
            repeat (tabela[s].ciclos) @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
